// File: rtl/blink_mmu.sv
// Z88 Blink bank-switching MMU: segment mapping, chip-enable decode, per-slot WAIT insertion.
// Optional write protection per slot is built when BLINK_MMU_WRPROT_EN is defined.
module blink_mmu #(
    parameter int           NSEG     = 4,
    parameter int           ADDR_W   = 16,
    parameter int           BANK_W   = 8,
    parameter logic [7:0]   IO_BASE  = 8'hD0,
    parameter int           WS_W     = 3,
    parameter int           WS_RESET = 3,
    localparam int          SB       = $clog2(NSEG),
    localparam int          MA_W     = BANK_W + ADDR_W - SB
) (
    input  logic              mck,
    input  logic              rin_n,
    input  logic [ADDR_W-1:0] ca,
    input  logic [7:0]        cdi,
    input  logic              mrq_n,
    input  logic              ior_n,
    input  logic              crd_n,
    output logic [MA_W-1:0]   ma,
    output logic              ipce_n,
    output logic              irce_n,
    output logic [2:0]        se_n,
    output logic              wrb_n,
    output logic              roe_n,
    output logic              wait_n,
    output logic [7:0]        cdo,
    output logic              cdo_oe,
    output logic              wp_viol
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] NS8 = 8'(NSEG);

    logic [BANK_W-1:0] sr [NSEG];
    logic [WS_W-1:0]   ws [4];
    logic [SB-1:0]     idx;
    logic [BANK_W-1:0] bank;
    logic [1:0]        slot;
    logic              mem, wp_blk;

    assign idx  = ca[ADDR_W-1 -: SB];
    assign bank = sr[idx];
    assign slot = bank[BANK_W-1 -: 2];
    assign mem  = !mrq_n;
    assign ma   = {bank, ca[ADDR_W-SB-1:0]};

    assign ipce_n = !(mem && slot == 2'd0 && !bank[BANK_W-3]);
    assign irce_n = !(mem && slot == 2'd0 &&  bank[BANK_W-3]);
    assign roe_n  = !(mem && !crd_n);
    assign wrb_n  = !(mem && crd_n && !wp_blk);

    for (genvar s = 1; s < 4; s++) begin : g_se
        assign se_n[s-1] = !(mem && slot == 2'(s));
    end

    // IO port decode on the low address byte; strobe on the first sampled-low cycle of ior_n
    logic [7:0]      off, rd_data;
    logic [SB-1:0]   seg_k;
    logic [1:0]      ws_s;
    logic            seg_hit, ws_hit, wp_hit, rd_hit;
    logic            ior_q, mrq_q, strobe, io_wr, io_rd;

    assign off     = ca[7:0] - IO_BASE;
    assign seg_hit = off < NS8;
    assign ws_hit  = (off >= NS8) && (off < NS8 + 8'd4);
    assign seg_k   = off[SB-1:0];
    assign ws_s    = off[1:0] - NS8[1:0];
    assign rd_hit  = seg_hit || ws_hit || wp_hit;
    assign strobe  = ior_q && !ior_n;
    assign io_wr   = strobe && crd_n;
    assign io_rd   = strobe && !crd_n;

`ifdef BLINK_MMU_WRPROT_EN
    logic [3:0] wp;

    assign wp_hit = off == NS8 + 8'd4;
    assign wp_blk = mem && crd_n && wp[slot];

    always_ff @(posedge mck) begin
        if (!rin_n) begin
            wp      <= '0;
            wp_viol <= 1'b0;
        end else begin
            if (io_wr && wp_hit) begin
                wp <= cdi[3:0];
                if (cdi[7]) wp_viol <= 1'b0;
            end
            // a blocked write in the same cycle as a clear keeps the flag set
            if (wp_blk) wp_viol <= 1'b1;
        end
    end
`else
    assign wp_hit  = 1'b0;
    assign wp_blk  = 1'b0;
    assign wp_viol = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (seg_hit)     rd_data = 8'(sr[seg_k]);
        else if (ws_hit) rd_data = 8'(ws[ws_s]);
`ifdef BLINK_MMU_WRPROT_EN
        else if (wp_hit) rd_data = {wp_viol, 3'b000, wp};
`endif
    end

    state_t          state, state_nx;
    logic [WS_W-1:0] cnt, cnt_nx, n;
    logic            wait_nx, fall;

    assign n    = ws[slot];
    assign fall = mrq_q && !mrq_n;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wait_nx  = wait_n;
        case (state)
            IDLE: if (fall) begin
                if (n == '0) begin
                    state_nx = DONE;
                    wait_nx  = 1'b1;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = n;
                    wait_nx  = 1'b0;
                end
            end
            WAIT: if (mrq_n) begin
                state_nx = IDLE;
                wait_nx  = 1'b1;
            end else if (cnt == WS_W'(1)) begin
                state_nx = DONE;
                wait_nx  = 1'b1;
            end else begin
                cnt_nx = cnt - WS_W'(1);
            end
            DONE: if (mrq_n) state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                wait_nx  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge mck) begin
        if (!rin_n) begin
            state  <= IDLE;
            cnt    <= '0;
            wait_n <= 1'b1;
            mrq_q  <= 1'b1;
            ior_q  <= 1'b1;
            cdo    <= '0;
            cdo_oe <= 1'b0;
            for (int k = 0; k < NSEG; k++) sr[k] <= '0;
            for (int k = 0; k < 4; k++)    ws[k] <= WS_W'(WS_RESET);
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            wait_n <= wait_nx;
            mrq_q  <= mrq_n;
            ior_q  <= ior_n;
            if (io_wr && seg_hit) sr[seg_k] <= BANK_W'(cdi);
            if (io_wr && ws_hit)  ws[ws_s]  <= cdi[WS_W-1:0];
            if (ior_n) begin
                cdo_oe <= 1'b0;
            end else if (io_rd) begin
                if (rd_hit) cdo <= rd_data;
                cdo_oe <= rd_hit;
            end
        end
    end
endmodule
